// File: rtl/encap_hdr_inserter_if.sv
// AXI-Stream bundle shared by the encapsulation engine input and output.
interface encap_hdr_inserter_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 1
);
  logic [DATA_W-1:0]   tdata;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/encap_hdr_inserter.sv
// Prepends a per-tid, byte-granular header to each AXI-Stream packet,
// realigning the payload across beats and emitting a tail beat on overflow.
module encap_hdr_inserter #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 0,
  parameter int MAX_HDR_BYTES   = 54,
  parameter int COUNTER_WIDTH   = 32,
  localparam int B        = AXIS_BUS_WIDTH / 8,
  localparam int EFF_ID   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int EFF_DEST = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int LW       = (MAX_HDR_BYTES > 0) ? $clog2(MAX_HDR_BYTES + 1) : 1,
  localparam int HDR_W    = (MAX_HDR_BYTES > 0) ? 8 * MAX_HDR_BYTES : 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  encap_hdr_inserter_if.slave          axis_in,
  encap_hdr_inserter_if.master         axis_out,
  output logic [EFF_ID-1:0]            hdr_cfg_sel,
  input  logic [LW-1:0]                hdr_cfg_len,
  input  logic [HDR_W-1:0]             hdr_cfg_data,
  input  logic                         hdr_cfg_drop,
  output logic [COUNTER_WIDTH-1:0]     pkt_count,
  output logic [COUNTER_WIDTH-1:0]     drop_count
);
  localparam int DATA_W = AXIS_BUS_WIDTH;
  localparam int OW     = (B > 1) ? $clog2(B) : 1;
  localparam int HP     = HDR_W + DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_DROP, S_HDR, S_BODY, S_TAIL} state_t;

  state_t                r_state;
  logic [HP-1:0]         r_hdr;
  logic [LW-1:0]         r_w;
  logic [OW-1:0]         r_o;
  logic [DATA_W-1:0]     r_resid;
  logic [B-1:0]          r_tail_keep;
  logic [EFF_ID-1:0]     r_tid;
  logic [EFF_DEST-1:0]   r_tdest;
  logic [DATA_W-1:0]     r_out_tdata;
  logic [B-1:0]          r_out_tkeep;
  logic [EFF_ID-1:0]     r_out_tid;
  logic [EFF_DEST-1:0]   r_out_tdest;
  logic                  r_out_tlast;
  logic                  r_out_tvalid;

  logic                  w_out_free;
  int                    w_len_i;
  int                    w_o_i;
  int                    w_sum;
  logic [HP-1:0]         w_hdr_load;
  logic [HP-1:0]         w_hdr_shift;
  logic [DATA_W-1:0]     w_body;
  logic [DATA_W-1:0]     w_resid_next;

  function automatic logic [B-1:0] f_keep(input int n);
    logic [B-1:0] k;
    for (int i = 0; i < B; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [DATA_W-1:0] f_bytemask(input int n);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < B; i++) m[8*i +: 8] = (i < n) ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic int f_count(input logic [B-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < B; i++) if (k[i]) c++;
    return c;
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] f_sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (v == '1) ? v : v + COUNTER_WIDTH'(1);
  endfunction

  assign hdr_cfg_sel  = axis_in.tid;
  assign w_out_free   = !r_out_tvalid || axis_out.tready;
  assign w_len_i      = (int'(hdr_cfg_len) > MAX_HDR_BYTES) ? MAX_HDR_BYTES : int'(hdr_cfg_len);
  assign w_o_i        = int'(r_o);
  assign w_sum        = f_count(axis_in.tkeep) + w_o_i;
  assign w_hdr_load   = {{DATA_W{1'b0}}, hdr_cfg_data};
  assign w_hdr_shift  = r_hdr >> DATA_W;
  assign w_body       = (axis_in.tdata << (8 * w_o_i)) | (r_resid & f_bytemask(w_o_i));
  assign w_resid_next = axis_in.tdata >> (8 * (B - w_o_i));

  assign axis_in.tready  = (r_state == S_DROP) || ((r_state == S_BODY) && w_out_free);
  assign axis_out.tdata  = r_out_tdata;
  assign axis_out.tkeep  = r_out_tkeep;
  assign axis_out.tid    = r_out_tid;
  assign axis_out.tdest  = r_out_tdest;
  assign axis_out.tlast  = r_out_tlast;
  assign axis_out.tvalid = r_out_tvalid;

  // Packet FSM: config latch, header beats, realigned body, tail, counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
      r_out_tkeep  <= '0;
      r_out_tdata  <= '0;
      r_out_tid    <= '0;
      r_out_tdest  <= '0;
      r_resid      <= '0;
      pkt_count    <= '0;
      drop_count   <= '0;
    end else begin
      if (r_out_tvalid && axis_out.tready) begin
        r_out_tvalid <= 1'b0;
        if (r_out_tlast) pkt_count <= f_sat_inc(pkt_count);
      end
      case (r_state)
        S_IDLE: begin
          if (axis_in.tvalid) begin
            r_tid   <= axis_in.tid;
            r_tdest <= axis_in.tdest;
            r_hdr   <= w_hdr_load;
            r_resid <= w_hdr_load[DATA_W-1:0];
            r_w     <= LW'(w_len_i / B);
            r_o     <= OW'(w_len_i % B);
            if (hdr_cfg_drop)      r_state <= S_DROP;
            else if (w_len_i >= B) r_state <= S_HDR;
            else                   r_state <= S_BODY;
          end
        end
        S_DROP: begin
          if (axis_in.tvalid && axis_in.tlast) begin
            drop_count <= f_sat_inc(drop_count);
            r_state    <= S_IDLE;
          end
        end
        S_HDR: begin
          if (w_out_free) begin
            r_out_tdata  <= r_hdr[DATA_W-1:0];
            r_out_tkeep  <= '1;
            r_out_tlast  <= 1'b0;
            r_out_tvalid <= 1'b1;
            r_out_tid    <= r_tid;
            r_out_tdest  <= r_tdest;
            r_hdr        <= w_hdr_shift;
            r_resid      <= w_hdr_shift[DATA_W-1:0];
            r_w          <= r_w - LW'(1);
            if (r_w == LW'(1)) r_state <= S_BODY;
          end
        end
        S_BODY: begin
          if (axis_in.tvalid && w_out_free) begin
            r_out_tdata  <= w_body;
            r_out_tvalid <= 1'b1;
            r_out_tid    <= r_tid;
            r_out_tdest  <= r_tdest;
            r_resid      <= w_resid_next;
            if (axis_in.tlast && (w_sum <= B)) begin
              r_out_tkeep <= f_keep(w_sum);
              r_out_tlast <= 1'b1;
              r_state     <= S_IDLE;
            end else if (axis_in.tlast) begin
              r_out_tkeep <= '1;
              r_out_tlast <= 1'b0;
              r_tail_keep <= f_keep(w_sum - B);
              r_state     <= S_TAIL;
            end else begin
              r_out_tkeep <= '1;
              r_out_tlast <= 1'b0;
            end
          end
        end
        S_TAIL: begin
          if (w_out_free) begin
            r_out_tdata  <= r_resid;
            r_out_tkeep  <= r_tail_keep;
            r_out_tlast  <= 1'b1;
            r_out_tvalid <= 1'b1;
            r_out_tid    <= r_tid;
            r_out_tdest  <= r_tdest;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encap_hdr_inserter.sv
// Directed bench for encap_hdr_inserter (B=8, MAX_HDR_BYTES=54).
module tb_encap_hdr_inserter;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  encap_hdr_inserter_if #(.DATA_W(64), .ID_W(4), .DEST_W(1)) in_if ();
  encap_hdr_inserter_if #(.DATA_W(64), .ID_W(4), .DEST_W(1)) out_if ();

  logic [3:0]   hdr_cfg_sel;
  logic [5:0]   hdr_cfg_len;
  logic [431:0] hdr_cfg_data;
  logic         hdr_cfg_drop;
  logic [31:0]  pkt_count;
  logic [31:0]  drop_count;

  int checks = 0;
  int errors = 0;
  logic [5:0] t_len  [16];
  logic       t_drop [16];
  logic       tog_mode;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  logic        cap_last[$];
  logic [3:0]  cap_tid[$];

  encap_hdr_inserter dut (
    .aclk        (aclk),
    .areset      (areset),
    .axis_in     (in_if),
    .axis_out    (out_if),
    .hdr_cfg_sel (hdr_cfg_sel),
    .hdr_cfg_len (hdr_cfg_len),
    .hdr_cfg_data(hdr_cfg_data),
    .hdr_cfg_drop(hdr_cfg_drop),
    .pkt_count   (pkt_count),
    .drop_count  (drop_count)
  );

  function automatic logic [7:0] hb(input logic [3:0] t, input int i);
    return 8'(i * 7 + int'(t) * 29 + 3);
  endfunction

  function automatic logic [7:0] pb(input int pk, input int j);
    return 8'(pk * 40 + j + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Software-built header table indexed by tid
  always_comb begin
    hdr_cfg_len  = t_len[hdr_cfg_sel];
    hdr_cfg_drop = t_drop[hdr_cfg_sel];
    hdr_cfg_data = '0;
    for (int i = 0; i < 54; i++) hdr_cfg_data[8*i +: 8] = hb(hdr_cfg_sel, i);
  end

  // Downstream ready: constant 1 or toggling every cycle
  always @(posedge aclk) begin
    #1;
    if (tog_mode) out_if.tready = ~out_if.tready;
    else          out_if.tready = 1'b1;
  end

  // Output capture and hold-while-stalled monitor
  logic        stall_pend = 1'b0;
  logic [63:0] p_data;
  logic [7:0]  p_keep;
  logic        p_last;
  always @(negedge aclk) begin
    if (areset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", 64'(out_if.tvalid), 64'd1);
        chk("stall_data", out_if.tdata, p_data);
        chk("stall_keep", 64'(out_if.tkeep), 64'(p_keep));
        chk("stall_last", 64'(out_if.tlast), 64'(p_last));
      end
      stall_pend = out_if.tvalid && !out_if.tready;
      p_data = out_if.tdata;
      p_keep = out_if.tkeep;
      p_last = out_if.tlast;
      if (out_if.tvalid && out_if.tready) begin
        cap_data.push_back(out_if.tdata);
        cap_keep.push_back(out_if.tkeep);
        cap_last.push_back(out_if.tlast);
        cap_tid.push_back(out_if.tid);
      end
    end
  end

  task automatic clear_cap();
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_tid.delete();
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [3:0] t, output int cyc);
    logic hs;
    in_if.tdata = d; in_if.tkeep = k; in_if.tlast = l; in_if.tid = t; in_if.tvalid = 1'b1;
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 300) begin
      @(negedge aclk);
      hs = in_if.tvalid && in_if.tready;
      @(posedge aclk); #1;
      cyc++;
    end
    if (!hs) chk("in_handshake_timeout", 64'(hs), 64'd1);
  endtask

  task automatic send_pkt(input logic [3:0] t, input int pk, input int nbytes, output int first);
    int nbeats, cyc, k;
    logic [63:0] d;
    nbeats = (nbytes + 7) / 8;
    first  = 0;
    for (int b = 0; b < nbeats; b++) begin
      k = (nbytes - 8*b > 8) ? 8 : nbytes - 8*b;
      d = '0;
      for (int j = 0; j < k; j++) d[8*j +: 8] = pb(pk, 8*b + j);
      send_beat(d, 8'((1 << k) - 1), (b == nbeats - 1), t, cyc);
      if (b == 0) first = cyc;
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic drain(input int n);
    int c;
    c = 0;
    while (cap_data.size() < n && c < 500) begin
      @(posedge aclk); c++;
    end
    repeat (6) @(posedge aclk);
    #1;
  endtask

  task automatic check_pkt(input string nm, input logic [3:0] t, input int hlen, input int pk,
                           input int nbytes, input logic [7:0] ek[$]);
    logic [7:0]  s[$];
    logic [63:0] ew, m;
    int nb;
    for (int i = 0; i < hlen; i++)   s.push_back(hb(t, i));
    for (int j = 0; j < nbytes; j++) s.push_back(pb(pk, j));
    chk({nm, "_beats"}, 64'(cap_data.size()), 64'(ek.size()));
    nb = (cap_data.size() < ek.size()) ? cap_data.size() : ek.size();
    for (int b = 0; b < nb; b++) begin
      ew = '0; m = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < s.size()) ew[8*j +: 8] = s[8*b + j];
        if (ek[b][j]) m[8*j +: 8] = 8'hFF;
      end
      chk($sformatf("%s_data%0d", nm, b), cap_data[b] & m, ew & m);
      chk($sformatf("%s_keep%0d", nm, b), 64'(cap_keep[b]), 64'(ek[b]));
      chk($sformatf("%s_last%0d", nm, b), 64'(cap_last[b]), 64'(b == ek.size() - 1));
      chk($sformatf("%s_tid%0d", nm, b), 64'(cap_tid[b]), 64'(t));
    end
    clear_cap();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ek[$];
    int fc;
    for (int i = 0; i < 16; i++) begin t_len[i] = 6'd0; t_drop[i] = 1'b0; end
    t_len[1] = 6'd14; t_len[2] = 6'd8; t_len[3] = 6'd5; t_drop[3] = 1'b1;
    t_len[4] = 6'd63; t_len[5] = 6'd54; t_len[6] = 6'd3;
    tog_mode = 1'b0;
    areset = 1'b1;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tlast = 1'b0;
    in_if.tid = '0; in_if.tdest = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_tlast",  64'(out_if.tlast), 64'd0);
    chk("rst_tkeep",  64'(out_if.tkeep), 64'd0);
    chk("rst_tdata",  out_if.tdata, 64'd0);
    chk("rst_in_tready", 64'(in_if.tready), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // len=14, 20-byte payload: one header word, tail beat
    send_pkt(4'd1, 1, 20, fc);
    chk("t1_first_accept_cycle", 64'(fc), 64'd3);
    drain(5);
    ek = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
    check_pkt("t1", 4'd1, 14, 1, 20, ek);
    chk("t1_pkt_count", 64'(pkt_count), 64'd1);

    // len=8, 8-byte payload: aligned, no tail
    send_pkt(4'd2, 2, 8, fc);
    drain(2);
    ek = '{8'hFF, 8'hFF};
    check_pkt("t2", 4'd2, 8, 2, 8, ek);

    // len=0: passthrough, single idle cycle before accept
    send_pkt(4'd0, 3, 20, fc);
    chk("t3_first_accept_cycle", 64'(fc), 64'd2);
    drain(3);
    ek = '{8'hFF, 8'hFF, 8'h0F};
    check_pkt("t3", 4'd0, 0, 3, 20, ek);
    chk("t3_pkt_count", 64'(pkt_count), 64'd3);

    // Dropped packet followed by a normal one
    send_pkt(4'd3, 4, 32, fc);
    send_pkt(4'd1, 5, 8, fc);
    drain(3);
    ek = '{8'hFF, 8'hFF, 8'h3F};
    check_pkt("t4", 4'd1, 14, 5, 8, ek);
    chk("t4_drop_count", 64'(drop_count), 64'd1);
    chk("t4_pkt_count", 64'(pkt_count), 64'd4);

    // Max header (clamped 63 -> 54 and exact 54) under toggling ready
    tog_mode = 1'b1;
    send_pkt(4'd4, 6, 13, fc);
    drain(9);
    ek = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07};
    check_pkt("t5a", 4'd4, 54, 6, 13, ek);
    send_pkt(4'd5, 7, 16, fc);
    drain(9);
    ek = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F};
    check_pkt("t5b", 4'd5, 54, 7, 16, ek);
    tog_mode = 1'b0;
    repeat (2) @(posedge aclk); #1;
    chk("t5_pkt_count", 64'(pkt_count), 64'd6);

    // Reset in the middle of a body
    send_beat(64'h1122334455667788, 8'hFF, 1'b0, 4'd6, fc);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    in_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("t6_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("t6_tkeep",  64'(out_if.tkeep), 64'd0);
    chk("t6_tdata",  out_if.tdata, 64'd0);
    chk("t6_tlast",  64'(out_if.tlast), 64'd0);
    chk("t6_tid",    64'(out_if.tid), 64'd0);
    chk("t6_in_tready", 64'(in_if.tready), 64'd0);
    chk("t6_pkt_count", 64'(pkt_count), 64'd0);
    chk("t6_drop_count", 64'(drop_count), 64'd0);
    clear_cap();
    @(posedge aclk); #1;
    send_pkt(4'd6, 9, 10, fc);
    drain(2);
    ek = '{8'hFF, 8'h1F};
    check_pkt("t7", 4'd6, 3, 9, 10, ek);
    chk("t7_pkt_count", 64'(pkt_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/encap_hdr_inserter.md
Name: encap_hdr_inserter

Overview:
Parametrised next-generation encapsulation engine: prepends an arbitrary-length, byte-granular header (0..MAX_HDR_BYTES) to each AXI-Stream packet, with the header selected per packet from a tid-indexed configuration table. It handles the cross-beat byte realignment, emits an extra tail beat when the shifted packet overflows the last word, and can drop packets whose configuration says so. It sits in the NMU egress path ahead of the MAC and replaces fixed-format encap with a generic header image built by software.

Parameters:
AXIS_BUS_WIDTH, 64, data width in bits; multiple of 8; B = AXIS_BUS_WIDTH/8 bytes per beat
AXIS_ID_WIDTH, 4, tid width; effective width is max(1, value)
AXIS_DEST_WIDTH, 0, tdest width; effective width is max(1, value)
MAX_HDR_BYTES, 54, largest header in bytes (>= 0); L = clog2(MAX_HDR_BYTES+1) bits
COUNTER_WIDTH, 32, width of statistics counters

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
axis_in_tdata  in  AXIS_BUS_WIDTH  input payload; byte 0 = tdata[7:0] is first on wire
axis_in_tid  in  EFF_ID  packet source id; also the config select
axis_in_tdest  in  EFF_DEST  packet dest; passed through
axis_in_tkeep  in  B  contiguous from bit 0; only the tlast beat may be partial
axis_in_tlast  in  1  end of packet
axis_in_tvalid  in  1  valid
axis_in_tready  out  1  ready
axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  as input  encapsulated stream
axis_out_tready  in  1  downstream ready
hdr_cfg_sel  out  EFF_ID  equals axis_in_tid (combinational)
hdr_cfg_len  in  L  header length in bytes; values > MAX_HDR_BYTES are clamped to MAX_HDR_BYTES
hdr_cfg_data  in  8*MAX_HDR_BYTES  header image; header byte i = bits [8i+7:8i]
hdr_cfg_drop  in  1  1 = discard the whole packet
pkt_count  out  COUNTER_WIDTH  packets fully emitted; saturating
drop_count  out  COUNTER_WIDTH  packets discarded; saturating

Behaviour:
- Reset: state IDLE; axis_out_tvalid=0, axis_out_tlast=0, tkeep/tdata/tid/tdest=0; axis_in_tready=0; counters=0; residual register cleared. A reset mid-packet abandons the packet; the remainder of the input packet is then treated as a new packet.
- All outputs are registered. An output beat updates when !axis_out_tvalid || axis_out_tready. tvalid holds with stable data until accepted.
- IDLE: axis_in_tready=0. When axis_in_tvalid=1, latch hdr_cfg_len, hdr_cfg_data, hdr_cfg_drop, tid and tdest. Compute W = len/B (full header words) and O = len%B. Next state is DROP if drop=1, else HDR if W>0, else BODY. This costs 1 cycle per packet and consumes no input beat.
- DROP: axis_in_tready=1. Beats are consumed and discarded. On the tlast handshake, increment drop_count and go to IDLE.
- HDR: emit W beats of header bytes [kB..kB+B-1] with tkeep all ones and tlast=0. No input is accepted. After the W-th beat is accepted, go to BODY.
- BODY: axis_in_tready = out-reg-free. Each accepted input beat produces one output beat:
  - output bytes [0..O-1] = residual, which holds the header tail on the first body beat and the previous input's top O bytes afterwards;
  - output bytes [O..B-1] = input bytes [0..B-O-1];
  - residual <= input bytes [B-O..B-1].
- Last input beat with K kept bytes:
  - if K+O <= B: out tlast=1, tkeep = low (K+O) ones; go to IDLE.
  - else: out tlast=0, tkeep all ones; go to TAIL.
  - O=0 gives pure passthrough alignment.
- TAIL: emit residual with tkeep = low (K+O-B) ones and tlast=1. Input is not ready. Go to IDLE.
- pkt_count increments on the accepted output tlast beat.
- Throughput is 1 beat/cycle in BODY. Per-packet overhead is 1 (IDLE) + W + (tail ? 1 : 0) cycles.
- out tid/tdest = the values latched in IDLE for every beat of the packet.
- A single-beat input packet is legal in all states.
- Counters stick at all ones.
- Clamped length applies before computing W and O.

Test Plan:
- B=8, len=14, 20-byte payload (beats 8,8,4 kept) -> 5 out beats: hdr0 0xFF, then hdr8-13 + pay0-1 0xFF, 0xFF, 0xFF, last 0x03 tlast; bytes match in order; pkt_count=1.
- len=8, 8-byte payload -> 2 beats, both tkeep 0xFF, payload beat bytes unchanged, no TAIL.
- len=0, 3-beat payload with last tkeep 0x0F -> output identical to input, 1 idle cycle before first beat.
- hdr_cfg_drop=1 for tid=3, 4-beat packet, then a normal packet -> no output for first packet, drop_count=1, second packet emitted correctly.
- len=54 (clamp check with len=63 as well), axis_out_tready toggling 1010... -> no lost or duplicated bytes; tvalid/tdata stable while stalled.
- areset asserted for 1 cycle during BODY -> all outputs 0 the next cycle, counters=0; next packet encapsulates correctly.
